// File: rtl/key_pkg.sv
// key_pkg: shared types and defaults for the key_conditioner block.
// Holds the debounce FSM state encoding, default parameter values and
// a helper that maps the ACTIVE_LOW polarity to the idle (released) pin level.
package key_pkg;

  // Default configuration. Debounce default is ~1 ms at a 50 MHz clock.
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Debounce FSM states. Explicit 2-bit encodings keep the register layout
  // stable for anything that probes the state bits.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Raw pin level that corresponds to "not pressed" for a given polarity.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer for a single asynchronous bit.
// Ports: clk, reset (sync, active-high), i_rst_val (value loaded on reset),
//        i_d (async input), o_q (synchronized output, STAGES cycles later).
// Parameter STAGES: number of flops, must be >= 2.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Reset loads every stage with the same level so that no spurious edge
  // propagates out of the chain after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {STAGES{i_rst_val}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces a raw pushbutton.
// Ports: clk, reset (sync, active-high), key_in (raw async button),
//        key_level (debounced, 1 = pressed), press_pulse / release_pulse
//        (one-cycle strobes on each committed press / release).
// Latency key_in edge -> key_level change: SYNC_STAGES + DEBOUNCE_CYCLES clk.
// Build option: define KEY_CONDITIONER_RELEASE_PULSE_EN to enable
// release_pulse; otherwise release_pulse is tied low (FSM and key_level
// behave identically either way).
// Legal ranges: SYNC_STAGES 2..4, DEBOUNCE_CYCLES 1..2^20.
module key_conditioner
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Counter value held while the last required sample is being taken:
  // the transition out of a stable state already counts as sample one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  // With a single-sample debounce the first differing sample commits
  // straight from the stable state; the WAIT state is then only a
  // one-cycle transit into the new stable state.
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  // ---------------------------------------------------------------------
  // Synchronizer and polarity normalisation
  // ---------------------------------------------------------------------
  logic w_rst_val;
  logic w_sync;
  logic w_sample;

  assign w_rst_val = released_level(ACTIVE_LOW);

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_rst_val (w_rst_val),
    .i_d       (key_in),
    .o_q       (w_sync)
  );

  // w_sample = 1 means "pressed" regardless of pin polarity.
  assign w_sample = ACTIVE_LOW ? ~w_sync : w_sync;

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  key_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_level;
  logic             r_press_pulse;

  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press_commit;
  logic             w_release_commit;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_press_commit   = 1'b0;
    w_release_commit = 1'b0;

    case (r_state)
      RELEASED: begin
        if (w_sample) begin
          w_state_nxt    = PRESS_WAIT;
          w_cnt_nxt      = CNT_ONE;
          w_press_commit = SINGLE;
        end else begin
          w_cnt_nxt = '0;
        end
      end

      PRESS_WAIT: begin
        if (SINGLE) begin
          // Press already committed on entry; finish the transit.
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (!w_sample) begin
          // Glitch: drop the pending press, restart on the next 1 sample.
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt    = HELD;
          w_cnt_nxt      = '0;
          w_press_commit = 1'b1;
        end else if (r_cnt < CNT_SAT) begin
          // Saturating increment: the count never wraps even if the
          // commit compare were ever bypassed.
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      HELD: begin
        if (!w_sample) begin
          w_state_nxt      = RELEASE_WAIT;
          w_cnt_nxt        = CNT_ONE;
          w_release_commit = SINGLE;
        end else begin
          w_cnt_nxt = '0;
        end
      end

      RELEASE_WAIT: begin
        if (SINGLE) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_sample) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt      = RELEASED;
          w_cnt_nxt        = '0;
          w_release_commit = 1'b1;
        end else if (r_cnt < CNT_SAT) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset abandons any pending change; no pulse can be produced while
  // reset is asserted because the registers are forced low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RELEASED;
      r_cnt         <= '0;
      r_key_level   <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_press_pulse <= w_press_commit;
      if (w_press_commit) begin
        r_key_level <= 1'b1;
      end else if (w_release_commit) begin
        r_key_level <= 1'b0;
      end
    end
  end

  assign key_level   = r_key_level;
  assign press_pulse = r_press_pulse;

`ifdef KEY_CONDITIONER_RELEASE_PULSE_EN
  logic r_release_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_release_pulse <= 1'b0;
    end else begin
      r_release_pulse <= w_release_commit;
    end
  end

  assign release_pulse = r_release_pulse;
`else
  assign release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed bench for key_conditioner with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 (expected latency 6).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_key_conditioner;

`ifdef KEY_CONDITIONER_RELEASE_PULSE_EN
  localparam int REL_EN = 1;
`else
  localparam int REL_EN = 0;
`endif

  logic clk;
  logic reset;
  logic key_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cyc0     = 0;

  int press_cnt   = 0;
  int release_cnt = 0;
  int both_cnt    = 0;

  key_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse === 1'b1)   press_cnt++;
    if (release_pulse === 1'b1) release_cnt++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for press_pulse; latency is relative to cyc0, -1 on timeout.
  task automatic wait_press(input int max, output int lat, output int lvl_prev);
    lat = -1;
    lvl_prev = -1;
    for (int i = 0; i < max; i++) begin
      lvl_prev = int'(key_level);
      tick();
      if (press_pulse === 1'b1) begin
        lat = cyc - cyc0;
        break;
      end
    end
  endtask

  // Wait (bounded) for key_level to fall; latency relative to cyc0.
  task automatic wait_release(input int max, output int lat);
    lat = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (key_level === 1'b0) begin
        lat = cyc - cyc0;
        break;
      end
    end
  endtask

  task automatic do_release(input string tag);
    int lat;
    cyc0 = cyc;
    key_in = 1'b1;
    wait_release(20, lat);
    chk({tag, "_latency"}, lat, 6);
    chk({tag, "_pulse"}, int'(release_pulse), REL_EN);
    tick();
    chk({tag, "_pulse_width"}, int'(release_pulse), 0);
    chk({tag, "_level_low"}, int'(key_level), 0);
    ticks(4);
  endtask

  initial begin
    int lat;
    int lvl_prev;
    int pc;

    reset  = 1'b1;
    key_in = 1'b1;
    ticks(3);
    chk("reset_key_level", int'(key_level), 0);
    chk("reset_press_pulse", int'(press_pulse), 0);
    chk("reset_release_pulse", int'(release_pulse), 0);

    reset = 1'b0;
    ticks(5);
    chk("idle_key_level", int'(key_level), 0);

    // Clean press.
    cyc0 = cyc;
    key_in = 1'b0;
    wait_press(20, lat, lvl_prev);
    chk("press_latency", lat, 6);
    chk("press_level_high", int'(key_level), 1);
    chk("press_level_before", lvl_prev, 0);
    tick();
    chk("press_pulse_width", int'(press_pulse), 0);
    chk("press_level_held", int'(key_level), 1);
    ticks(4);

    do_release("release1");

    // Glitch of 3 pressed cycles must be rejected.
    pc = press_cnt;
    key_in = 1'b0;
    ticks(3);
    key_in = 1'b1;
    ticks(15);
    chk("glitch_no_press", press_cnt, pc);
    chk("glitch_level_low", int'(key_level), 0);

    // Late glitch: 3 pressed, 1 released, then pressed held.
    cyc0 = cyc;
    key_in = 1'b0;
    ticks(3);
    key_in = 1'b1;
    tick();
    key_in = 1'b0;
    wait_press(30, lat, lvl_prev);
    chk("late_glitch_latency", lat, 10);
    chk("late_glitch_level", int'(key_level), 1);
    ticks(4);

    do_release("release2");

    // Reset mid-debounce after two pressed samples, key kept pressed.
    key_in = 1'b0;
    ticks(4);
    pc = press_cnt;
    reset = 1'b1;
    tick();
    chk("midrst_no_pulse", int'(press_pulse), 0);
    chk("midrst_level_low", int'(key_level), 0);
    reset = 1'b0;
    cyc0 = cyc;
    wait_press(20, lat, lvl_prev);
    chk("midrst_press_latency", lat, 6);
    tick();
    chk("midrst_one_press", press_cnt, pc + 1);
    ticks(4);

    do_release("release3");

    // Bounce train: toggle every 2 cycles for 40 cycles, then hold pressed.
    pc = press_cnt;
    for (int i = 0; i < 20; i++) begin
      key_in = ~key_in;
      ticks(2);
    end
    chk("bounce_no_early_press", press_cnt, pc);
    key_in = 1'b0;
    cyc0 = cyc;
    wait_press(30, lat, lvl_prev);
    chk("bounce_press_latency", lat, 6);
    ticks(10);
    chk("bounce_one_press", press_cnt, pc + 1);
    chk("bounce_level_high", int'(key_level), 1);

    chk("total_press_pulses", press_cnt, 4);
    chk("total_release_pulses", release_cnt, 3 * REL_EN);
    chk("pulses_never_together", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable samples needed to commit a change (legal range 1..2^20).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means key_in=0 is pressed.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port key_in, input, 1, raw asynchronous pushbutton.
REQ-007 SHALL have port key_level, output, 1, debounced level, 1 = pressed regardless of ACTIVE_LOW.
REQ-008 SHALL have port press_pulse, output, 1, single-cycle strobe on each committed press, suitable for the downstream sticky edge trap.
REQ-009 SHALL have port release_pulse, output, 1, single-cycle strobe on each committed release.

Function
REQ-010 SHALL pass key_in through SYNC_STAGES flops, then normalise polarity so that sample=1 means pressed.
REQ-011 SHALL implement FSM states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-012 RELEASED: sample=1 -> PRESS_WAIT with cnt<=1; otherwise stay, cnt<=0.
REQ-013 PRESS_WAIT: sample=0 -> RELEASED with cnt<=0 (glitch rejected); sample=1 and cnt<DEBOUNCE_CYCLES -> cnt<=cnt+1; commit when the DEBOUNCE_CYCLES-th consecutive 1 sample is taken.
REQ-014 HELD and RELEASE_WAIT SHALL mirror REQ-012/013 with the sample polarity inverted.
REQ-015 On press commit: key_level<=1 and press_pulse<=1 at the same edge, state becomes HELD; press_pulse SHALL be 0 the following cycle.
REQ-016 On release commit: key_level<=0, release_pulse<=1 for one cycle, state becomes RELEASED.
REQ-017 With DEBOUNCE_CYCLES=1, commit SHALL occur on the first differing sample; the WAIT states still occur as one-cycle transits and the total latency still obeys REQ-018.
REQ-018 Latency from a key_in edge held stable to key_level change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES clk cycles.
REQ-019 cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1); cnt SHALL saturate and never wrap.
REQ-020 A glitch on the sample taken immediately before commit SHALL reject the change and restart counting on the next differing sample.
REQ-021 press_pulse and release_pulse SHALL never both be 1 in the same cycle, and two pulses SHALL be at least DEBOUNCE_CYCLES cycles apart.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 Reset SHALL set state=RELEASED, cnt=0, key_level=0, press_pulse=0, release_pulse=0, and set all synchronizer flops to the released level.
REQ-024 Reset asserted mid-debounce SHALL abandon the pending change with no pulse.
REQ-025 A key held through reset deassertion SHALL produce a press_pulse after REQ-018 latency.

Configuration
REQ-026 Macro KEY_CONDITIONER_RELEASE_PULSE_EN defined: release_pulse behaves per REQ-016.
REQ-027 Macro KEY_CONDITIONER_RELEASE_PULSE_EN undefined: release_pulse SHALL be tied 0, while key_level and the FSM behave identically to the defined case.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state enum and default parameter constants (DEFAULT_SYNC_STAGES, DEFAULT_DEBOUNCE_CYCLES).
REQ-029 The synchronizer SHALL be sub-module sync_chain (parameter STAGES, reset value input), reusable elsewhere.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-030 Clean press: key_in 1->0 and held -> key_level=1 and press_pulse=1 exactly 6 cycles later, pulse width 1.
REQ-031 Glitch rejection: key_in low for 3 cycles, then high -> no press_pulse, key_level stays 0, FSM back to RELEASED.
REQ-032 Late glitch: 3 pressed samples, 1 released sample, then pressed held -> press_pulse 4 cycles after the pressed samples resume (10 cycles after the original edge).
REQ-033 Release: from HELD, key_in 0->1 held -> release_pulse after 6 cycles with macro defined; always 0 with macro undefined.
REQ-034 Reset mid-debounce: reset for 1 cycle after 2 pressed samples with key held -> no pulse during reset, press_pulse 6 cycles after reset deasserts.
REQ-035 Bounce train: key_in toggling every 2 cycles for 40 cycles, then held low -> exactly one press_pulse, 6 cycles after the final edge.
